// File: rtl/hex_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : hex_seg_scan_driver
// Description : Multi-digit hex-to-7-segment scan driver. The host fills a
//               shadow buffer and requests a commit. The shadow buffer is copied
//               to the display buffer only at a frame boundary, so the display
//               never tears. Supports leading-zero blanking, a blank input and
//               selectable output polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_seg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 16,
    parameter int ACTIVE_LOW = 0,
    parameter int LZ_BLANK   = 1,
    localparam int c_aw      = $clog2(DIGITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [c_aw-1:0]   wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              wr_dp,
    input  logic              commit,
    input  logic              blank,
    output logic              pending,
    output logic [6:0]        seg_out,
    output logic              dp_out,
    output logic [DIGITS-1:0] digit_en
);

    localparam int                c_dw       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_dw-1:0]   c_div_last = c_dw'(SCAN_DIV - 1);
    localparam logic [c_aw-1:0]   c_dig_last = c_aw'(DIGITS - 1);
    localparam logic [c_aw:0]     c_num_dig  = (c_aw + 1)'(DIGITS);
    localparam logic              c_pol      = (ACTIVE_LOW != 0);
    localparam logic              c_lz_on    = (LZ_BLANK != 0);
    localparam logic [DIGITS-1:0] c_en_one   = DIGITS'(1);

    logic [c_dw-1:0]   r_div_cnt;
    logic [c_aw-1:0]   r_dig_idx;
    logic [4:0]        r_shadow  [DIGITS];
    logic [4:0]        r_display [DIGITS];
    logic              r_pending;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic [DIGITS-1:0] r_en;

    logic              w_tick;
    logic              w_frame_end;
    logic              w_apply;
    logic              w_wr_ok;
    logic [DIGITS-1:0] w_zero_tail;
    logic              w_dark;
    logic [4:0]        w_sel;

    // Seven-segment pattern {g,f,e,d,c,b,a} for a hex nibble, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign w_tick      = (r_div_cnt == c_div_last);
    assign w_frame_end = w_tick && (r_dig_idx == c_dig_last);
    assign w_apply     = w_frame_end && (r_pending || commit);
    assign w_wr_ok     = wr_en && ({1'b0, wr_addr} < c_num_dig);
    assign w_sel       = r_display[r_dig_idx];

    // Leading-zero detection: bit i set when digit i and every digit above it is empty.
    always_comb begin
        w_zero_tail = '0;
        w_zero_tail[DIGITS-1] = (r_display[DIGITS-1] == 5'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            w_zero_tail[i] = (r_display[i] == 5'd0) && w_zero_tail[i+1];
        end
        w_dark = c_lz_on && (r_dig_idx != '0) && w_zero_tail[r_dig_idx];
    end

    // Scan timing: per-digit dwell counter and the selected digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_dig_idx <= '0;
        end else begin
            if (w_tick) begin
                r_div_cnt <= '0;
                r_dig_idx <= (r_dig_idx == c_dig_last) ? '0 : r_dig_idx + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // Host-side shadow buffer, written one digit per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_shadow[i] <= 5'd0;
            end
        end else if (w_wr_ok) begin
            r_shadow[wr_addr] <= {wr_dp, wr_data};
        end
    end

    // Commit handshake: latch the request, copy the shadow only at a frame boundary.
    // The copy reads the registered shadow, so a same-cycle write is not included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_display[i] <= 5'd0;
            end
        end else begin
            if (commit) begin
                r_pending <= 1'b1;
            end
            if (w_apply) begin
                r_pending <= 1'b0;
                for (int i = 0; i < DIGITS; i++) begin
                    r_display[i] <= r_shadow[i];
                end
            end
        end
    end

    // Registered outputs for the digit selected this cycle, polarity applied last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= {7{c_pol}};
            r_dp  <= c_pol;
            r_en  <= {DIGITS{c_pol}};
        end else if (blank) begin
            r_seg <= {7{c_pol}};
            r_dp  <= c_pol;
            r_en  <= {DIGITS{c_pol}};
        end else begin
            r_seg <= (w_dark ? 7'h00 : hex_to_seg(w_sel[3:0])) ^ {7{c_pol}};
            r_dp  <= (w_dark ? 1'b0 : w_sel[4]) ^ c_pol;
            r_en  <= (c_en_one << r_dig_idx) ^ {DIGITS{c_pol}};
        end
    end

    assign pending  = r_pending;
    assign seg_out  = r_seg;
    assign dp_out   = r_dp;
    assign digit_en = r_en;

endmodule
`default_nettype wire

// File: tb/tb_hex_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_seg_scan_driver
// Description : Self-checking bench for hex_seg_scan_driver. Two instances
//               share the stimulus: A (4 digits, active-high, LZ blanking) and
//               B (3 digits, active-low, no LZ blanking). A cycle-level model
//               derives the scan position arithmetically from the cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_seg_scan_driver;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       commit;
    logic       blank;

    logic       pend_a, dp_a, pend_b, dp_b;
    logic [6:0] seg_a, seg_b;
    logic [3:0] en_a;
    logic [2:0] en_b;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = instance A, 1 = instance B
    int  nd [2] = '{4, 3};
    bit  lz [2] = '{1'b1, 1'b0};
    bit  al [2] = '{1'b0, 1'b1};
    int  m_shadow  [2][8];
    int  m_display [2][8];
    bit  m_pending [2];
    int  m_n;
    int  e_seg [2];
    int  e_dp  [2];
    int  e_en  [2];
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    hex_seg_scan_driver #(.DIGITS(4), .SCAN_DIV(SD), .ACTIVE_LOW(0), .LZ_BLANK(1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_dp(wr_dp), .commit(commit), .blank(blank), .pending(pend_a),
        .seg_out(seg_a), .dp_out(dp_a), .digit_en(en_a));

    hex_seg_scan_driver #(.DIGITS(3), .SCAN_DIV(SD), .ACTIVE_LOW(1), .LZ_BLANK(0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_dp(wr_dp), .commit(commit), .blank(blank), .pending(pend_b),
        .seg_out(seg_b), .dp_out(dp_b), .digit_en(en_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Predict the effect of the coming edge, apply it, then compare both instances.
    task automatic step();
        int  d;
        bit  bnd;
        bit  dark;
        int  sel;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int j = 0; j < 8; j++) begin
                    m_shadow[m][j]  = 0;
                    m_display[m][j] = 0;
                end
                m_pending[m] = 1'b0;
                e_seg[m] = 0; e_dp[m] = 0; e_en[m] = 0;
            end else begin
                d    = (m_n / SD) % nd[m];
                bnd  = (m_n % SD == SD - 1) && (d == nd[m] - 1);
                dark = lz[m] && (d > 0);
                for (int j = d; j < nd[m]; j++) begin
                    if (m_display[m][j] != 0) dark = 1'b0;
                end
                sel = m_display[m][d];
                if (blank) begin
                    e_seg[m] = 0; e_dp[m] = 0; e_en[m] = 0;
                end else begin
                    e_seg[m] = dark ? 0 : int'(seg_tab[sel % 16]);
                    e_dp[m]  = dark ? 0 : sel / 16;
                    e_en[m]  = 1 << d;
                end
                if (bnd && (m_pending[m] || commit)) begin
                    for (int j = 0; j < 8; j++) m_display[m][j] = m_shadow[m][j];
                    m_pending[m] = 1'b0;
                end else if (commit) begin
                    m_pending[m] = 1'b1;
                end
                if (wr_en && (int'(wr_addr) < nd[m]))
                    m_shadow[m][wr_addr] = 16 * int'(wr_dp) + int'(wr_data);
            end
        end
        m_n = rst ? 0 : m_n + 1;
        @(posedge clk);
        #1;
        chk("seg_a",  {25'd0, seg_a}, e_seg[0]);
        chk("dp_a",   {31'd0, dp_a},  e_dp[0]);
        chk("en_a",   {28'd0, en_a},  e_en[0]);
        chk("pend_a", {31'd0, pend_a}, {31'd0, m_pending[0]});
        chk("seg_b",  {25'd0, seg_b}, e_seg[1] ^ 32'h7F);
        chk("dp_b",   {31'd0, dp_b},  e_dp[1] ^ 32'h1);
        chk("en_b",   {29'd0, en_b},  e_en[1] ^ 32'h7);
        chk("pend_b", {31'd0, pend_b}, {31'd0, m_pending[1]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int addr, input int data, input bit dp);
        wr_en = 1'b1; wr_addr = 2'(addr); wr_data = 4'(data); wr_dp = dp;
        step();
        wr_en = 1'b0;
    endtask

    task automatic commit_pulse();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    // Step until instance A shows digit idx, mid-dwell.
    task automatic show(input int idx);
        for (int i = 0; i < 24; i++) begin
            if ((((m_n - 1) / SD) % 4 == idx) && ((m_n - 1) % SD == 1)) break;
            step();
        end
    endtask

    // Step until the coming edge is a frame boundary of instance A.
    task automatic align_boundary_a();
        for (int i = 0; i < 20; i++) begin
            if ((m_n % SD == SD - 1) && ((m_n / SD) % 4 == 3)) break;
            step();
        end
    endtask

    task automatic align_mid();
        for (int i = 0; i < 8; i++) begin
            if (m_n % SD == 1) break;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b0;
        commit = 1'b0; blank = 1'b0; m_n = 0;
        run(3);
        chk("rst_en_a",  {28'd0, en_a},  32'h0);
        chk("rst_seg_b", {25'd0, seg_b}, 32'h7F);
        chk("rst_en_b",  {29'd0, en_b},  32'h7);

        // T1: scan order after reset release
        rst = 1'b0;
        step();
        chk("t1_first_digit", {28'd0, en_a}, 32'h1);
        run(16);

        // T2: write 1..4, commit mid-frame
        wr(0, 1, 0); wr(1, 2, 0); wr(2, 3, 0); wr(3, 4, 0);
        align_mid();
        commit_pulse();
        chk("t2_pending", {31'd0, pend_a}, 32'h1);
        run(20);
        show(0); chk("t2_d0", {25'd0, seg_a}, 32'h06);
        show(1); chk("t2_d1", {25'd0, seg_a}, 32'h5B);
        show(2); chk("t2_d2", {25'd0, seg_a}, 32'h4F);
        show(3); chk("t2_d3", {25'd0, seg_a}, 32'h66);
        chk("t2_pend_clr", {31'd0, pend_a}, 32'h0);

        // T3: commit on the boundary with a same-cycle write
        align_boundary_a();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hF; wr_dp = 1'b0; commit = 1'b1;
        step();
        wr_en = 1'b0; commit = 1'b0;
        chk("t3_pend", {31'd0, pend_a}, 32'h0);
        show(0); chk("t3_old", {25'd0, seg_a}, 32'h06);
        commit_pulse();
        run(24);
        show(0); chk("t3_new", {25'd0, seg_a}, 32'h71);

        // T4: leading-zero blanking on 0x0050, then dp on digit 3
        wr(0, 0, 0); wr(1, 5, 0); wr(2, 0, 0); wr(3, 0, 0);
        commit_pulse();
        run(24);
        show(3); chk("t4_d3_dark", {25'd0, seg_a}, 32'h0); chk("t4_d3_en", {28'd0, en_a}, 32'h8);
        show(0); chk("t4_d0", {25'd0, seg_a}, 32'h3F);
        show(1); chk("t4_d1", {25'd0, seg_a}, 32'h6D);
        show(2); chk("t4_d2_dark", {25'd0, seg_a}, 32'h0);
        wr(3, 0, 1);
        commit_pulse();
        run(24);
        show(2); chk("t4_d2_lit", {25'd0, seg_a}, 32'h3F);
        show(3); chk("t4_d3_lit", {25'd0, seg_a}, 32'h3F); chk("t4_d3_dp", {31'd0, dp_a}, 32'h1);

        // T5: blank pulse of 10 clocks
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_blank_en", {28'd0, en_a}, 32'h0);
        end
        blank = 1'b0;
        run(20);

        // Randomised traffic including out-of-range addresses for instance B
        for (int i = 0; i < 600; i++) begin
            wr_en   = 1'($urandom % 2);
            wr_addr = 2'($urandom % 4);
            wr_data = 4'($urandom % 16);
            wr_dp   = 1'($urandom % 4 == 0);
            commit  = 1'($urandom % 10 == 0);
            blank   = 1'($urandom % 20 == 0);
            rst     = 1'($urandom % 150 == 0);
            step();
        end
        wr_en = 1'b0; commit = 1'b0; blank = 1'b0; rst = 1'b0;
        run(8);

        // T6: reset mid-scan with a commit pending
        wr(1, 9, 1); wr(2, 7, 0);
        align_mid();
        commit_pulse();
        chk("t6_pend_set", {31'd0, pend_b}, 32'h1);
        rst = 1'b1;
        step();
        chk("t6_seg_b", {25'd0, seg_b}, 32'h7F);
        chk("t6_en_b",  {29'd0, en_b},  32'h7);
        chk("t6_pend",  {31'd0, pend_b}, 32'h0);
        rst = 1'b0;
        run(20);
        show(0); chk("t6_disp0", {25'd0, seg_a}, 32'h3F);
        show(1); chk("t6_disp1_dark", {25'd0, seg_a}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
